// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM slave behind a simple enable/ready bus with a fixed,
// parameterised access latency and out-of-window error response.
module bus_sram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_wstrb,
   input  logic        bus_write,
   input  logic        bus_enable,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic        bus_err
);

   localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q, wdata_q;
   logic [3:0]        wstrb_q;
   logic              write_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              accept, complete, in_range;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       mem [DEPTH_WORDS];

   // 33-bit limit so a window ending at the top of the address space cannot wrap
   assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < LIMIT);
   assign idx      = IDX_W'((addr_q - BASE_ADDR) >> 2);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = 32'd0;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      accept   = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_enable) begin
               accept  = 1'b1;
               cnt_d   = WAIT_LD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A withdrawn request aborts silently, even on the final wait edge
            if (!bus_enable) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               complete = 1'b1;
               state_d  = RESP;
               ready_d  = 1'b1;
               err_d    = !in_range;
               if (in_range && !write_q) begin
                  rdata_d = mem[idx];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Request fields are captured once at acceptance; later bus changes are ignored
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus_addr;
         wdata_q <= bus_wdata;
         wstrb_q <= bus_wstrb;
         write_q <= bus_write;
      end
   end

   always_ff @(posedge clk) begin
      if (complete && in_range && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign bus_rdata = rdata_q;
   assign bus_ready = ready_q;
   assign bus_err   = err_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: a driver queues expected responses from a
// word-array reference model, a negedge monitor checks every response it sees.
module tb_bus_sram_slave;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          DEPTH = 1024;
   localparam int          WAIT  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wstrb;
   logic        write, enable, ready, err;

   logic [31:0] a0, wd0, rd0;
   logic [3:0]  ws0;
   logic        wr0, en0, rdy0, err0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          issue;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [31:0] mem_m [int];

   bus_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .bus_addr(addr), .bus_wdata(wdata), .bus_wstrb(wstrb),
      .bus_write(write), .bus_enable(enable), .bus_rdata(rdata), .bus_ready(ready),
      .bus_err(err)
   );

   bus_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus_addr(a0), .bus_wdata(wd0), .bus_wstrb(ws0),
      .bus_write(wr0), .bus_enable(en0), .bus_rdata(rd0), .bus_ready(rdy0),
      .bus_err(err0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      longint unsigned x, lo, hi;
      x  = longint'(a);
      lo = longint'(BASE);
      hi = lo + 4 * DEPTH;
      return (x >= lo) && (x < hi);
   endfunction

   function automatic int pool_word(input int k);
      return (k == 16) ? DEPTH - 1 : k;
   endfunction

   // Monitor: every ready pulse consumes one expectation; otherwise outputs idle at zero
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1, expected no response (cycle %0d)", cyc);
         end else begin
            mon_e = q.pop_front();
            check("err", {31'd0, err}, {31'd0, mon_e.err});
            check("rdata", rdata, mon_e.rdata);
            check("latency", 32'(cyc - mon_e.issue), 32'(WAIT + 2));
         end
      end else begin
         check("idle_rdata", rdata, 32'd0);
         check("idle_err", {31'd0, err}, 32'd0);
      end
   end

   // Issue one access (called #1 after a rising edge with the slave idle) and wait for it
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w);
      exp_t        e;
      logic [31:0] word;
      int          idx;
      bit          ok;
      addr = a; wdata = d; wstrb = s; write = w; enable = 1'b1;
      e.issue = cyc;
      e.err   = !in_win(a);
      e.rdata = 32'd0;
      if (in_win(a)) begin
         idx  = int'((a - BASE) >> 2);
         word = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
         if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            mem_m[idx] = word;
         end else begin
            e.rdata = word;
         end
      end
      q.push_back(e);
      @(posedge clk); #1;
      addr = $urandom; wdata = $urandom; wstrb = 4'($urandom); write = 1'($urandom);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got no ready for addr %h, expected one", a);
         q.delete();
      end
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit          prev;
      int          cnt, consec, last;
      logic [31:0] a;
      bit          ok;

      addr = '0; wdata = '0; wstrb = '0; write = 1'b0; enable = 1'b0;
      a0 = BASE + 32'd4; wd0 = '0; ws0 = '0; wr0 = 1'b0; en0 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      rst_n = 1'b1;

      // Preload the word pool used by all later reads
      for (int k = 0; k < 17; k++) access(BASE + 32'(4 * pool_word(k)), $urandom, 4'hF, 1'b1);

      access(32'h0001_0010, 32'hA5A5_1234, 4'hF, 1'b1);
      access(32'h0001_0010, 32'h0, 4'h0, 1'b0);
      access(32'h0001_0010, 32'hFFFF_FFFF, 4'b0101, 1'b1);
      access(32'h0001_0010, 32'h0, 4'h0, 1'b0);
      access(32'h0000_FFFC, 32'h0, 4'h0, 1'b0);
      access(32'h0001_1000, 32'h0, 4'h0, 1'b0);
      access(32'h0001_0FFC, 32'h0, 4'h0, 1'b0);
      access(32'h0001_1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
      access(32'h0001_0022, 32'h0BAD_F00D, 4'h0, 1'b1);
      access(32'h0001_0020, 32'h0, 4'h0, 1'b0);

      // Write withdrawn during the second BUSY cycle must leave no trace
      addr = 32'h0001_0020; wdata = 32'h1111_1111; wstrb = 4'hF; write = 1'b1; enable = 1'b1;
      idle_cycles(2);
      enable = 1'b0;
      idle_cycles(6);
      access(32'h0001_0020, 32'h0, 4'h0, 1'b0);

      // Reset in the middle of a write's BUSY phase
      addr = 32'h0001_0030; wdata = 32'h5555_AAAA; wstrb = 4'hF; write = 1'b1; enable = 1'b1;
      idle_cycles(2);
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("rst_busy_ready", {31'd0, ready}, 32'd0);
      check("rst_busy_err", {31'd0, err}, 32'd0);
      check("rst_busy_rdata", rdata, 32'd0);
      idle_cycles(2);
      rst_n = 1'b1;
      access(32'h0001_0030, 32'h0, 4'h0, 1'b0);

      // Reset while a read response is on the bus clears the outputs at once
      addr = 32'h0001_0010; write = 1'b0; wstrb = 4'h0; enable = 1'b1;
      idle_cycles(1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("rst_resp_seen", {31'd0, ok}, 32'd1);
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("rst_resp_ready", {31'd0, ready}, 32'd0);
      check("rst_resp_rdata", rdata, 32'd0);
      idle_cycles(2);
      rst_n = 1'b1;
      access(32'h0001_0010, 32'h0, 4'h0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            a = BASE + 32'(4 * pool_word($urandom_range(0, 16))) + 32'($urandom_range(0, 3));
         end else begin
            case ($urandom_range(0, 3))
               0:       a = BASE - 32'd4;
               1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
               2:       a = 32'h8000_0000 | 32'($urandom);
               default: a = 32'hFFFF_FFFC;
            endcase
         end
         access(a, $urandom, 4'($urandom), 1'($urandom));
         idle_cycles($urandom_range(0, 2));
      end

      // Zero-wait instance with enable held high: one response every third cycle
      en0 = 1'b1;
      prev = 1'b0; cnt = 0; consec = 0; last = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rdy0) begin
            cnt++;
            if (prev) consec++;
            check("w0_err", {31'd0, err0}, 32'd0);
            if (last >= 0) check("w0_gap", 32'(i - last), 32'd3);
            last = i;
         end
         prev = rdy0;
      end
      en0 = 1'b0;
      check("w0_count", 32'(cnt), 32'd10);
      check("w0_consecutive", 32'(consec), 32'd0);

      idle_cycles(4);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
